// File: rtl/cla_pkg.sv
// cla_pkg: shared FSM state type and slice-count helpers for the multi-cycle adder
package cla_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int nslice(input int w, input int s);
    return w / s;
  endfunction
  function automatic int idx_w(input int w, input int s);
    return (w / s) > 1 ? $clog2(w / s) : 1;
  endfunction
endpackage

// File: rtl/cla_slice.sv
// cla_slice: combinational SLICE-bit adder, 4-bit lookahead groups with rippled remainder
module cla_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             cmsb
);
  localparam int NG = SLICE / 4;
  logic [SLICE-1:0] g, p;
  logic [SLICE:0] c;
  assign g = x & y;
  assign p = x ^ y;
  always_comb begin
    c = '0;
    c[0] = cin;
    for (int j = 0; j < NG; j++) begin
      c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & c[4*j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
      c[4*j+4] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
    end
    for (int i = 4 * NG; i < SLICE; i++) c[i+1] = g[i] | (p[i] & c[i]);
  end
  assign s = p ^ c[SLICE-1:0];
  assign cout = c[SLICE];
  assign cmsb = c[SLICE-1];
endmodule

// File: rtl/addsub_multicycle.sv
// addsub_multicycle: add/subtract one SLICE per cycle through a shared CLA slice, with overflow and zero flags
module addsub_multicycle
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  input  logic             sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovflow,
  output logic             zero
);
  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int KW = idx_w(WIDTH, SLICE);
  state_t state, state_n;
  logic [WIDTH-1:0] op_a, op_b, res_n;
  logic [KW-1:0] k;
  logic [SLICE-1:0] s;
  logic carry, sgn, sub, accept, last, cout, cmsb;
  assign accept = start && state != RUN;
  assign last = k == KW'(NSLICE - 1);
  cla_slice #(.SLICE(SLICE)) u_slice (
    .x(op_a[k*SLICE +: SLICE]),
    .y(op_b[k*SLICE +: SLICE]),
    .cin(carry),
    .s(s),
    .cout(cout),
    .cmsb(cmsb)
  );
  always_comb begin
    res_n = result;
    res_n[k*SLICE +: SLICE] = s;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb state_n = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a <= '0;
      op_b <= '0;
      sgn <= 1'b0;
      sub <= 1'b0;
      carry <= 1'b0;
      k <= '0;
      result <= '0;
      ovflow <= 1'b0;
      zero <= 1'b0;
    end else if (accept) begin
      op_a <= a;
      op_b <= subtract ? ~b : b;
      sgn <= sign;
      sub <= subtract;
      carry <= subtract;
      k <= '0;
      result <= '0;
    end else if (state == RUN) begin
      result <= res_n;
      carry <= cout;
      k <= last ? '0 : k + 1'b1;
      if (last) begin
        ovflow <= sgn ? (cmsb ^ cout) : (sub ? ~cout : cout);
        zero <= res_n == '0;
      end
    end
  end
endmodule
